// File: rtl/rx_uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding,
// default widths and FIFO entry field positions.
package rx_uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PARITY = 2'd1,
        ST_STOP   = 2'd2
    } rx_state_e;

    // Entry layout is {framing_err, parity_err, data}
    function automatic int perr_bit(input int width);
        return width;
    endfunction

    function automatic int ferr_bit(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word-fall-through FIFO for checked frames; flags a registered
// overrun pulse when a push is refused.
module rx_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overrun;

    logic w_pop;
    logic w_full;
    logic w_push_ok;

    assign w_pop     = (r_count != '0) & i_ready;
    assign w_full    = (r_count == FULL_CNT);
    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_push_ok = i_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overrun <= i_push & ~w_push_ok;
        end
    end

    assign o_valid   = (r_count != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_overrun = r_overrun;

endmodule

// File: rtl/rx_frame_checker.sv
// Samples parity and stop bits after the deserializer, computes the
// frame errors and queues {ferr, perr, data} for the consumer.
module rx_frame_checker
    import rx_uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit PARITY_ODD       = 1'b0,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in_synced,
    input  logic                        sampling_strobe,
    input  logic                        is_parity_stage,
    input  logic                        data_is_valid,
    input  logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INPUT_DATA_WIDTH-1:0] out_data,
    output logic                        out_parity_error,
    output logic                        out_framing_error,
    output logic                        overrun
);

    localparam int EW = INPUT_DATA_WIDTH + 2;

    rx_state_e                   r_state;
    rx_state_e                   w_next;
    logic                        r_dv_q;
    logic [INPUT_DATA_WIDTH-1:0] r_data_hold;
    logic                        r_par_bit;

    logic          w_dv_rise;
    logic          w_hold_en;
    logic          w_par_en;
    logic          w_push;
    logic          w_perr;
    logic          w_ferr;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign w_dv_rise = data_is_valid & ~r_dv_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_dv_q      <= 1'b0;
            r_data_hold <= '0;
            r_par_bit   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dv_q  <= data_is_valid;
            if (w_hold_en) begin
                r_data_hold <= received_data;
            end
            if (w_par_en) begin
                r_par_bit <= serial_in_synced;
            end
        end
    end

    // A new data_is_valid edge always wins: partial frames are dropped silently
    always_comb begin
        w_next    = r_state;
        w_hold_en = 1'b0;
        w_par_en  = 1'b0;
        w_push    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_dv_rise) begin
                    w_hold_en = 1'b1;
                    w_next    = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_dv_rise) begin
                    w_hold_en = 1'b1;
                end else if (sampling_strobe & is_parity_stage) begin
                    w_par_en = 1'b1;
                    w_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_dv_rise) begin
                    w_hold_en = 1'b1;
                    w_next    = ST_PARITY;
                end else if (sampling_strobe) begin
                    w_push = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_perr  = (^r_data_hold) ^ r_par_bit ^ PARITY_ODD;
    assign w_ferr  = ~serial_in_synced;
    assign w_entry = {w_ferr, w_perr, r_data_hold};

    rx_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_push    (w_push),
        .i_data    (w_entry),
        .i_ready   (out_ready),
        .o_valid   (out_valid),
        .o_data    (w_head),
        .o_overrun (overrun)
    );

    assign out_data          = w_head[INPUT_DATA_WIDTH-1:0];
    assign out_parity_error  = w_head[perr_bit(INPUT_DATA_WIDTH)];
    assign out_framing_error = w_head[ferr_bit(INPUT_DATA_WIDTH)];

endmodule
